// File: rtl/score_link_decoder.sv
// score_link_decoder: receive side of a 74HC595-style three-wire display link.
// It oversamples data, SCLK and RCLK, deserialises 16-bit frames, shows the
// latched segment/digit bytes and turns good frames back into player scores.
module score_link_decoder #(
   parameter int DIG_P1 = 0,
   parameter int DIG_P2 = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       driver_pin_1,
   input  logic       driver_pin_2,
   input  logic       driver_pin_3,
   output logic [7:0] seg_code,
   output logic [7:0] dig_sel,
   output logic [3:0] score_player1,
   output logic [3:0] score_player2,
   output logic       frame_valid,
   output logic       frame_err
);

   localparam logic [7:0] P1_MASK = 8'b1 << DIG_P1;
   localparam logic [7:0] P2_MASK = 8'b1 << DIG_P2;

   // [0],[1] form the synchroniser, [2] is the edge-detect delay stage.
   // Data takes the same path so it stays aligned with the SCLK edge.
   logic [2:0]  data_sync;
   logic [2:0]  sclk_sync;
   logic [2:0]  rclk_sync;
   logic        sclk_rise;
   logic        rclk_rise;
   logic [15:0] sr;
   logic [4:0]  bit_cnt;
   logic [7:0]  seg_nodp;
   logic        digit_ok;
   logic [3:0]  digit_val;
   logic        sel_p1;
   logic        sel_p2;
   logic        good;

   assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
   assign rclk_rise = rclk_sync[1] & ~rclk_sync[2];

   // Synchronise the three link pins into the clk domain.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_sync <= '0;
         sclk_sync <= '0;
         rclk_sync <= '0;
      end else begin
         data_sync <= {data_sync[1:0], driver_pin_1};
         sclk_sync <= {sclk_sync[1:0], driver_pin_2};
         rclk_sync <= {rclk_sync[1:0], driver_pin_3};
      end
   end

   // Decode the segment byte (dp forced off) back to a digit and check framing.
   always_comb begin
      digit_ok  = 1'b1;
      digit_val = 4'd0;
      seg_nodp  = sr[15:8] | 8'h80;
      case (seg_nodp)
         8'hC0:   digit_val = 4'd0;
         8'hF9:   digit_val = 4'd1;
         8'hA4:   digit_val = 4'd2;
         8'hB0:   digit_val = 4'd3;
         8'h99:   digit_val = 4'd4;
         8'h92:   digit_val = 4'd5;
         8'h82:   digit_val = 4'd6;
         8'hF8:   digit_val = 4'd7;
         8'h80:   digit_val = 4'd8;
         8'h90:   digit_val = 4'd9;
         default: digit_ok  = 1'b0;
      endcase
      sel_p1 = (sr[7:0] == P1_MASK);
      sel_p2 = (sr[7:0] == P2_MASK);
      good   = (bit_cnt == 5'd16) && (sel_p1 || sel_p2) && digit_ok;
   end

   // Shift register and saturating bit counter; a coincident latch starts a
   // new frame whose first bit is the one shifted in this same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sr      <= '0;
         bit_cnt <= '0;
      end else begin
         if (sclk_rise)
            sr <= {sr[14:0], data_sync[1]};
         if (rclk_rise)
            bit_cnt <= sclk_rise ? 5'd1 : 5'd0;
         else if (sclk_rise && bit_cnt != 5'd31)
            bit_cnt <= bit_cnt + 5'd1;
      end
   end

   // Output latch: raw bytes always update, scores only on a good frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         seg_code      <= 8'hFF;
         dig_sel       <= 8'h00;
         score_player1 <= 4'd0;
         score_player2 <= 4'd0;
         frame_valid   <= 1'b0;
         frame_err     <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         if (rclk_rise) begin
            seg_code    <= sr[15:8];
            dig_sel     <= sr[7:0];
            frame_valid <= good;
            frame_err   <= ~good;
            if (good && sel_p1)
               score_player1 <= digit_val;
            else if (good && sel_p2)
               score_player2 <= digit_val;
         end
      end
   end

endmodule
